// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  // Fetch sequencer states: idle after reset, issue a request, wait for its
  // response, or drain a response made stale by a redirect.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  // A bubble carries an all-zero word so the decoder produces all-zero controls.
  localparam logic [31:0] INSTR_NOP = 32'h0;

  // Instructions are 4 bytes wide.
  localparam int PC_STEP = 4;

  // Bit range of the main-decoder opcode field inside an instruction word.
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 21;

endpackage

// File: rtl/fetch_stage_if.sv
// Request/response handshake between the fetch stage and instruction memory.
interface fetch_stage_if #(
  parameter int N = 64
) ();

  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_ready;
  logic         imem_rvalid;
  logic [31:0]  imem_rdata;

  // The fetch stage drives requests and consumes responses.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  // Instruction memory accepts requests and returns responses.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_stage_hold_buf.sv
// One-entry {instr, pc} buffer that catches a response arriving while decode
// is stalled. Clear wins over load, and load wins over take.
module fetch_hold_buf
  import fetch_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         take,
  input  logic         clear,
  input  logic [31:0]  load_instr,
  input  logic [N-1:0] load_pc,
  output logic         full,
  output logic [31:0]  instr,
  output logic [N-1:0] pc
);

  // Capture a parked response and free the slot once decode consumes it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      full  <= 1'b0;
      instr <= INSTR_NOP;
      pc    <= '0;
    end else if (clear) begin
      full  <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (take) begin
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register. Owns the PC, keeps at
// most one request outstanding to instruction memory, and presents
// {instr_D, pc_D} to decode.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int           N        = 64,
  parameter logic [N-1:0] PC_RESET = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_stage_if.master        imem,
  input  logic                 stall_D,
  input  logic                 flush_D,
  input  logic                 redirect,
  input  logic [N-1:0]         redirect_pc,
  output logic [31:0]          instr_D,
  output logic [OP_MSB-OP_LSB:0] op_D,
  output logic [N-1:0]         pc_D,
  output logic                 valid_D
);

  fetch_state_t state, state_next;

  logic [N-1:0] pc;
  logic [N-1:0] req_pc;

  logic         issue;
  logic         rsp;
  logic         buf_full;
  logic         buf_load;
  logic         buf_take;
  logic [31:0]  buf_instr;
  logic [N-1:0] buf_pc;

  // A request is issued when it is offered and memory accepts it; a response
  // is only meaningful while waiting for the request it answers.
  assign issue = imem.imem_req & imem.imem_ready;
  assign rsp   = (state == WAIT) & imem.imem_rvalid;

  // Park a response when decode is stalled; hand the parked word to decode as
  // soon as decode may load and nothing is invalidating IF/ID.
  assign buf_load = rsp & stall_D & ~redirect;
  assign buf_take = buf_full & ~stall_D & ~flush_D & ~redirect;

  fetch_hold_buf #(.N(N)) u_hold_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (buf_load),
    .take       (buf_take),
    .clear      (redirect),
    .load_instr (imem.imem_rdata),
    .load_pc    (req_pc),
    .full       (buf_full),
    .instr      (buf_instr),
    .pc         (buf_pc)
  );

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one outstanding request, stale responses drained after a redirect.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  state_next = ISSUE;
      ISSUE: begin
        if (issue) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          state_next = ISSUE;
        end else if (redirect) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (imem.imem_rvalid) begin
          state_next = ISSUE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request outputs: offer the current PC only when the result has somewhere
  // to go and the PC is neither held by a stall nor being redirected.
  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc;
    if (reset && state == ISSUE && !buf_full && !stall_D && !redirect) begin
      imem.imem_req = 1'b1;
    end
  end

  // PC and the address of the request in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc     <= PC_RESET;
      req_pc <= PC_RESET;
    end else if (redirect) begin
      pc     <= redirect_pc;
    end else if (issue) begin
      pc     <= pc + N'(PC_STEP);
      req_pc <= pc;
    end
  end

  // IF/ID register: redirect and flush bubble it, stall holds it, otherwise it
  // loads the parked word first, then a live response, else a bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_D <= 1'b0;
      instr_D <= INSTR_NOP;
      pc_D    <= '0;
    end else if (redirect || flush_D) begin
      valid_D <= 1'b0;
      instr_D <= INSTR_NOP;
    end else if (!stall_D) begin
      if (buf_full) begin
        valid_D <= 1'b1;
        instr_D <= buf_instr;
        pc_D    <= buf_pc;
      end else if (rsp) begin
        valid_D <= 1'b1;
        instr_D <= imem.imem_rdata;
        pc_D    <= req_pc;
      end else begin
        valid_D <= 1'b0;
        instr_D <= INSTR_NOP;
      end
    end
  end

  assign op_D = instr_D[OP_MSB:OP_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small instruction-memory model whose
// response latency is adjustable.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall_D;
  logic        flush_D;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [31:0] instr_D;
  logic [10:0] op_D;
  logic [63:0] pc_D;
  logic        valid_D;

  int checks;
  int errors;

  int          mem_lat;
  bit          pend;
  int          cnt;
  logic [63:0] pend_addr;

  fetch_stage_if #(.N(64)) imem ();

  fetch_stage #(.N(64), .PC_RESET(64'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem),
    .stall_D     (stall_D),
    .flush_D     (flush_D),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_D     (instr_D),
    .op_D        (op_D),
    .pc_D        (pc_D),
    .valid_D     (valid_D)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: an LDUR-class word tagged with the low address bits.
  function automatic logic [31:0] memWord(input logic [63:0] addr);
    return {16'hF840, addr[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, present the memory
  // response due this cycle, record an accepted request at the rising edge,
  // and return at the next falling edge where outputs are sampled.
  task automatic applyStimulus(input logic rst_n, input logic st, input logic fl,
                               input logic rd, input logic [63:0] rpc);
    logic        issue_seen;
    logic [63:0] addr_seen;
    reset       = rst_n;
    stall_D     = st;
    flush_D     = fl;
    redirect    = rd;
    redirect_pc = rpc;
    imem.imem_ready = 1'b1;
    if (pend && cnt == 1) begin
      imem.imem_rvalid = 1'b1;
      imem.imem_rdata  = memWord(pend_addr);
      pend = 1'b0;
    end else begin
      imem.imem_rvalid = 1'b0;
      imem.imem_rdata  = 32'hDEAD_BEEF;
      if (pend) cnt--;
    end
    #1;
    issue_seen = (imem.imem_req === 1'b1);
    addr_seen  = imem.imem_addr;
    @(posedge clk);
    if (issue_seen) begin
      pend      = 1'b1;
      cnt       = mem_lat;
      pend_addr = addr_seen;
    end
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mem_lat = 1;
    pend = 1'b0;
    cnt = 0;
    pend_addr = '0;
    reset = 1'b0;
    stall_D = 1'b0;
    flush_D = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    imem.imem_ready = 1'b1;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata = '0;
    @(negedge clk);

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("rst_valid", valid_D, 0);
    checkOutput("rst_instr", instr_D, 0);
    checkOutput("rst_pc_D", pc_D, 0);
    checkOutput("rst_req", imem.imem_req, 0);

    // Streaming with 1-cycle memory: one instruction every 2 cycles
    idleCycle();
    checkOutput("s0_req", imem.imem_req, 1);
    checkOutput("s0_addr", imem.imem_addr, 64'h0);
    idleCycle();
    checkOutput("s0_wait_req", imem.imem_req, 0);
    idleCycle();
    checkOutput("s0_valid", valid_D, 1);
    checkOutput("s0_pc_D", pc_D, 64'h0);
    checkOutput("s0_op", op_D, 11'h7C2);
    checkOutput("s0_instr", instr_D, 32'hF840_0000);
    checkOutput("s1_addr", imem.imem_addr, 64'h4);
    idleCycle();
    checkOutput("s1_bubble", valid_D, 0);
    idleCycle();
    checkOutput("s1_valid", valid_D, 1);
    checkOutput("s1_pc_D", pc_D, 64'h4);
    checkOutput("s2_addr", imem.imem_addr, 64'h8);
    idleCycle();
    idleCycle();
    checkOutput("s2_pc_D", pc_D, 64'h8);
    checkOutput("s2_instr", instr_D, 32'hF840_0008);

    // Stall while a response arrives: word parked, no new request
    idleCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
      checkOutput("stall_req", imem.imem_req, 0);
      checkOutput("stall_instr", instr_D, 32'h0);
      checkOutput("stall_valid", valid_D, 0);
    end
    idleCycle();
    checkOutput("unstall_valid", valid_D, 1);
    checkOutput("unstall_pc_D", pc_D, 64'hC);
    checkOutput("unstall_instr", instr_D, 32'hF840_000C);
    checkOutput("unstall_addr", imem.imem_addr, 64'h10);
    checkOutput("unstall_req", imem.imem_req, 1);

    // Redirect while waiting on a slow response: stale word dropped
    mem_lat = 3;
    idleCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 64'h100);
    checkOutput("rd_req", imem.imem_req, 0);
    checkOutput("rd_valid", valid_D, 0);
    idleCycle();
    checkOutput("drain_req", imem.imem_req, 0);
    idleCycle();
    checkOutput("drop_valid", valid_D, 0);
    checkOutput("rd_next_req", imem.imem_req, 1);
    checkOutput("rd_next_addr", imem.imem_addr, 64'h100);
    mem_lat = 1;
    idleCycle();
    checkOutput("rd_wait_valid", valid_D, 0);
    idleCycle();
    checkOutput("rd_pc_D", pc_D, 64'h100);
    checkOutput("rd_instr", instr_D, 32'hF840_0100);

    // Flush together with stall: bubble wins, PC held
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    checkOutput("fl_valid", valid_D, 0);
    checkOutput("fl_instr", instr_D, 32'h0);
    checkOutput("fl_addr", imem.imem_addr, 64'h104);
    idleCycle();
    idleCycle();
    checkOutput("fl_next_pc_D", pc_D, 64'h104);
    checkOutput("fl_next_valid", valid_D, 1);

    // PC wrap at the top of the address space
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("wrap_addr0", imem.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    idleCycle();
    idleCycle();
    checkOutput("wrap_pc_D", pc_D, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("wrap_instr", instr_D, 32'hF840_FFFC);
    checkOutput("wrap_addr1", imem.imem_addr, 64'h0);

    // Reset during WAIT with a response in the same cycle
    idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("rw_valid", valid_D, 0);
    checkOutput("rw_instr", instr_D, 32'h0);
    checkOutput("rw_pc_D", pc_D, 64'h0);
    checkOutput("rw_req", imem.imem_req, 0);
    checkOutput("rw_op", op_D, 11'h0);
    idleCycle();
    checkOutput("rw_first_req", imem.imem_req, 1);
    checkOutput("rw_first_addr", imem.imem_addr, 64'h0);
    idleCycle();
    idleCycle();
    checkOutput("rw_post_valid", valid_D, 1);
    checkOutput("rw_post_instr", instr_D, 32'hF840_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
